// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD sector buffer.
package sd_pkg;

  localparam int SECTOR_BYTES           = 512;
  localparam int DEFAULT_TIMEOUT_CYCLES = 25_000_000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    ISSUE_WR,
    RD_STREAM,
    WR_STREAM,
    FINISH
  } sector_state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// 512x8 true dual-port sector RAM with registered reads (read-first).
// Port A belongs to the host, port B to the stream engine.
module sd_sector_ram
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] addr_a,
  input  logic       we_a,
  input  logic [7:0] wdata_a,
  output logic [7:0] rdata_a,
  input  logic [8:0] addr_b,
  input  logic       we_b,
  input  logic [7:0] wdata_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [SECTOR_BYTES];

  // Contents are deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[addr_a];
      rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer front end: turns host read/write commands into the SD
// controller's rd/wr byte-stream handshake around a 512-byte RAM.
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int LBA_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_read,
  input  logic             cmd_write,
  input  logic [LBA_W-1:0] lba,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [8:0]       buf_addr,
  input  logic             buf_we,
  input  logic [7:0]       buf_wdata,
  output logic [7:0]       buf_rdata,
  input  logic             sd_ready,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic [31:0]      sd_address,
  input  logic [7:0]       sd_dout,
  input  logic             sd_byte_available,
  output logic [7:0]       sd_din,
  input  logic             sd_ready_for_next_byte
);

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]      FULL_CNT  = 10'(SECTOR_BYTES);

  sector_state_t   state, state_next;
  logic [9:0]      byte_cnt;
  logic            skip;
  logic [WD_W-1:0] wd;
  logic            avail_r, avail_q, req_r, req_q;
  logic [7:0]      dout_r;
  logic [7:0]      ram_b_rdata;
  logic [8:0]      ram_b_addr;
  logic            cmd_ok, rd_take, wr_take, wr_skip, timeout, sector_full;

  assign cmd_ok      = (state == IDLE) && sd_ready && (cmd_read || cmd_write);
  assign sector_full = (byte_cnt == FULL_CNT);
  assign rd_take     = (state == RD_STREAM) && avail_r && !avail_q && !sector_full;
  assign wr_skip     = (state == WR_STREAM) && req_r && !req_q && !skip;
  assign wr_take     = (state == WR_STREAM) && req_r && !req_q && skip && !sector_full;
  assign timeout     = (state != IDLE) && (wd == '0);
  // Look one byte ahead on a counted request so sd_din is ready in time.
  assign ram_b_addr  = wr_take ? byte_cnt[8:0] + 9'd1 : byte_cnt[8:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (cmd_ok) state_next = cmd_read ? ISSUE_RD : ISSUE_WR;
      ISSUE_RD:  if (!sd_ready) state_next = RD_STREAM;
      ISSUE_WR:  if (!sd_ready) state_next = WR_STREAM;
      RD_STREAM: if (sector_full) state_next = FINISH;
      WR_STREAM: if (sector_full) state_next = FINISH;
      FINISH:    if (sd_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_comb begin
    busy   = (state != IDLE);
    sd_rd  = (state == ISSUE_RD);
    sd_wr  = (state == ISSUE_WR);
    sd_din = (state == WR_STREAM) ? ram_b_rdata : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avail_r <= 1'b0;
      avail_q <= 1'b0;
      req_r   <= 1'b0;
      req_q   <= 1'b0;
      dout_r  <= '0;
    end else begin
      avail_r <= sd_byte_available;
      avail_q <= avail_r;
      req_r   <= sd_ready_for_next_byte;
      req_q   <= req_r;
      dout_r  <= sd_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      skip       <= 1'b0;
      error      <= 1'b0;
      done       <= 1'b0;
      sd_address <= '0;
      wd         <= WD_RELOAD;
    end else begin
      done <= (state == FINISH) && sd_ready && !timeout;
      if (cmd_ok) begin
        sd_address <= 32'(lba);
        error      <= 1'b0;
        byte_cnt   <= '0;
        skip       <= 1'b0;
      end else begin
        if (rd_take || wr_take) byte_cnt <= byte_cnt + 10'd1;
        if (wr_skip) skip <= 1'b1;
        if (timeout) error <= 1'b1;
      end
      if ((state_next != state) || rd_take || wr_take || wr_skip) wd <= WD_RELOAD;
      else if (state != IDLE)                                     wd <= wd - WD_W'(1);
    end
  end

  sd_sector_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .addr_a  (buf_addr),
    .we_a    (buf_we && !busy),
    .wdata_a (buf_wdata),
    .rdata_a (buf_rdata),
    .addr_b  (ram_b_addr),
    .we_b    (rd_take),
    .wdata_b (dout_r),
    .rdata_b (ram_b_rdata)
  );

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Randomized bench for sd_sector_buffer: a controller model drives the byte
// streams while a sector-level model of the buffer predicts host-visible data.
module tb_sd_sector_buffer;
  import sd_pkg::*;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_read = 1'b0, cmd_write = 1'b0;
  logic [31:0] lba = '0;
  logic        busy, done, error;
  logic [8:0]  buf_addr = '0;
  logic        buf_we = 1'b0;
  logic [7:0]  buf_wdata = '0;
  logic [7:0]  buf_rdata;
  logic        sd_ready = 1'b1;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout = '0;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sd_din;
  logic        sd_ready_for_next_byte = 1'b0;

  sd_sector_buffer #(.TIMEOUT_CYCLES(TMO), .LBA_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_read(cmd_read), .cmd_write(cmd_write), .lba(lba),
    .busy(busy), .done(done), .error(error),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_address(sd_address),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .sd_din(sd_din),
    .sd_ready_for_next_byte(sd_ready_for_next_byte)
  );

  always #20 clk = ~clk;

  int         n_checks = 0, n_fail = 0;
  logic [7:0] model_ram [SECTOR_BYTES];
  bit         known [SECTOR_BYTES];
  logic [7:0] captured [SECTOR_BYTES];
  bit         op_active = 0, op_is_read = 0, rst_seen = 0, exp_valid = 0;
  logic [7:0] exp_rd = '0;
  int         done_cnt = 0, wr_bad = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    rst_seen <= reset;
    cyc      <= cyc + 1;
  end

  // Per-cycle compare: reset values, host read port, request exclusivity.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_sd_rd", sd_rd, 0);
      check("rst_sd_wr", sd_wr, 0);
      check("rst_sd_address", sd_address, 0);
      check("rst_sd_din", sd_din, 8'hFF);
      check("rst_buf_rdata", buf_rdata, 0);
    end else if (exp_valid) begin
      check("buf_rdata", buf_rdata, exp_rd);
    end
    if (done) done_cnt++;
    if (sd_wr && op_is_read) wr_bad++;
    if (sd_rd && sd_wr) wr_bad++;
    exp_valid = !reset && !op_active && known[buf_addr];
    exp_rd    = model_ram[buf_addr];
    if (buf_we && !reset && !op_active) begin
      model_ram[buf_addr] = buf_wdata;
      known[buf_addr]     = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a);
    int hold;
    lba = a; cmd_read = rd; cmd_write = wr; op_active = 1; op_is_read = rd;
    tick();
    cmd_read = 0; cmd_write = 0;
    check("req_rise", rd ? sd_rd : sd_wr, 1);
    check("addr_latched", sd_address, a);
    check("busy_set", busy, 1);
    check("error_cleared", error, 0);
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      tick();
      check("req_held", rd ? sd_rd : sd_wr, 1);
    end
    sd_ready = 0;
    tick();
    check("req_drop", rd ? sd_rd : sd_wr, 0);
  endtask

  task automatic stream_rd(input int n, input bit rnd, input bit inject, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      repeat ($urandom_range(1, 3)) tick();
      d = rnd ? 8'($urandom) : 8'(i);
      sd_dout = d; sd_byte_available = 1;
      model_ram[i] = d; known[i] = 1'b1; last = cyc;
      if (inject && i == 200) begin
        cmd_write = 1; buf_we = 1; buf_addr = 9'd5; buf_wdata = ~model_ram[5];
      end
      tick();
      sd_byte_available = 0; cmd_write = 0; buf_we = 0;
    end
  endtask

  task automatic stream_wr();
    sd_ready_for_next_byte = 1;
    tick();
    sd_ready_for_next_byte = 0;
    for (int k = 0; k < SECTOR_BYTES; k++) begin
      repeat ($urandom_range(1, 3)) tick();
      captured[k] = sd_din;
      check("wr_byte", sd_din, model_ram[k]);
      sd_ready_for_next_byte = 1;
      tick();
      sd_ready_for_next_byte = 0;
    end
  endtask

  task automatic finish_op(input bit is_rd, input int extra);
    int base;
    base = done_cnt;
    repeat (3) tick();
    for (int e = 0; e < extra; e++) begin
      sd_dout = 8'hEE;
      if (is_rd) sd_byte_available = 1; else sd_ready_for_next_byte = 1;
      tick();
      sd_byte_available = 0; sd_ready_for_next_byte = 0;
      tick();
    end
    tick();
    check("no_early_done", done_cnt - base, 0);
    check("busy_in_finish", busy, 1);
    sd_ready = 1;
    tick();
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("no_error", error, 0);
    tick();
    check("done_single", done, 0);
    check("done_count", done_cnt - base, 1);
    check("sd_din_idle", sd_din, 8'hFF);
    op_active = 0; op_is_read = 0;
  endtask

  task automatic dump();
    for (int a = 0; a < SECTOR_BYTES; a++) begin
      buf_addr = 9'(a);
      tick();
    end
    tick();
  endtask

  task automatic peek(input string name, input logic [8:0] a, input logic [7:0] e);
    buf_addr = a;
    tick();
    check(name, buf_rdata, e);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL global_watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  last, base;
    bit  seen;
    repeat (3) tick();
    reset = 0;
    tick();
    check("idle_busy", busy, 0);

    // Command with the controller not ready is ignored.
    sd_ready = 0; cmd_read = 1;
    tick();
    cmd_read = 0;
    check("ignored_cmd_rd", sd_rd, 0);
    check("ignored_cmd_busy", busy, 0);
    sd_ready = 1;
    tick();

    // Read LBA 0x1234 with an incrementing pattern, extra strobes after 512.
    issue(1, 0, 32'h0000_1234);
    check("lit_sd_address", sd_address, 32'h0000_1234);
    stream_rd(SECTOR_BYTES, 0, 0, last);
    finish_op(1, 2);
    dump();
    peek("lit_rd_000", 9'h000, 8'h00);
    peek("lit_rd_037", 9'h037, 8'h37);
    peek("lit_rd_1ff", 9'h1FF, 8'hFF);

    // Host fill then write LBA 7.
    for (int a = 0; a < SECTOR_BYTES; a++) begin
      buf_addr = 9'(a); buf_we = 1; buf_wdata = 8'hA5 ^ 8'(a);
      tick();
    end
    buf_we = 0;
    dump();
    issue(0, 1, 32'd7);
    stream_wr();
    check("lit_wr_first", captured[0], 8'hA5);
    check("lit_wr_last", captured[511], 8'h5A);
    finish_op(0, 1);

    // Host write and write command during an active read are ignored.
    issue(1, 0, 32'($urandom));
    stream_rd(SECTOR_BYTES, 1, 1, last);
    finish_op(1, 0);
    dump();

    // Stall after 100 bytes: timeout counts from the counted edge, which
    // trails the raw strobe by the two-stage input pipeline.
    base = done_cnt;
    issue(1, 0, 32'($urandom));
    stream_rd(100, 1, 0, last);
    seen = 0;
    for (int w = 0; w < TMO + 50 && !seen; w++) begin
      tick();
      if (error) seen = 1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_latency", cyc - last, TMO + 2);
    check("timeout_busy", busy, 0);
    check("timeout_sd_rd", sd_rd, 0);
    op_active = 0; op_is_read = 0;
    repeat (5) tick();
    check("error_sticky", error, 1);
    check("timeout_no_done", done_cnt - base, 0);
    sd_ready = 1;
    tick();
    issue(1, 0, 32'hCAFE_0001);
    stream_rd(SECTOR_BYTES, 1, 0, last);
    finish_op(1, 0);
    dump();

    // Reset in the middle of a read, then a fresh read.
    issue(1, 0, 32'h0000_0BAD);
    stream_rd(300, 1, 0, last);
    repeat (2) tick();
    reset = 1; sd_ready = 1; op_active = 0; op_is_read = 0;
    base = done_cnt;
    tick();
    reset = 0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_sd_rd", sd_rd, 0);
    check("rst_mid_address", sd_address, 0);
    repeat (3) tick();
    check("rst_mid_no_done", done_cnt - base, 0);
    issue(1, 0, 32'h0000_0055);
    stream_rd(SECTOR_BYTES, 1, 0, last);
    finish_op(1, 0);
    dump();

    // Simultaneous read and write commands: read wins.
    issue(1, 1, 32'h0000_0777);
    stream_rd(SECTOR_BYTES, 1, 0, last);
    finish_op(1, 1);
    dump();

    check("no_sd_wr_during_read", wr_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
